// File: rtl/pwm_pkg.sv
// Shared types for the dead-time PWM output stage.
package pwm_pkg;

   localparam int DT_WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      OFF   = 3'd0,
      DT_LH = 3'd1,
      HIGH  = 3'd2,
      DT_HL = 3'd3,
      LOW   = 3'd4,
      FAULT = 3'd5
   } state_t;

   // Which switch was conducting just before the current dead interval.
   typedef enum logic [1:0] {
      SIDE_NONE = 2'd0,
      SIDE_HIGH = 2'd1,
      SIDE_LOW  = 2'd2
   } side_t;

   function automatic logic is_dt(state_t s);
      return (s == DT_LH) || (s == DT_HL);
   endfunction

endpackage

// File: rtl/pwm_dt_timer.sv
// Dead-interval down-counter: loaded on entry to a dead interval, ticks while
// inside it. expired is high once the count has reached 1 or below, so a
// loaded value of 0 still yields a single dead cycle.
module pwm_dt_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         expired
);

   logic [W-1:0] cnt;

   // Load takes priority; decrement saturates at zero.
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (tick && (cnt != '0))
         cnt <= cnt - W'(1);
   end

   assign expired = (cnt <= W'(1));

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with dead-time insertion, short-pulse absorption
// and a latched fault. Gate outputs are registered decodes of the next state,
// so they always match the state register and never overlap.
module pwm_deadtime
   import pwm_pkg::*;
#(
   parameter int DT_WIDTH = DT_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                pwm_in,
   input  logic [DT_WIDTH-1:0] dead_time,
   input  logic                fault,
   input  logic                fault_clear,
   output logic                hs_out,
   output logic                ls_out,
   output logic                dt_active,
   output logic                fault_latched,
   output logic                pulse_drop
);

   state_t state;
   state_t nxt;
   side_t  side;
   logic   dt_load;
   logic   dt_tick;
   logic   dt_expired;

   // Next-state selection: fault beats everything, then enable, then pwm_in.
   always_comb begin
      nxt = state;
      if (fault) begin
         nxt = FAULT;
      end else if (state == FAULT) begin
         if (fault_clear) nxt = OFF;
      end else if (!enable) begin
         nxt = OFF;
      end else begin
         case (state)
            OFF:          nxt = pwm_in ? DT_LH : DT_HL;
            HIGH:         if (!pwm_in) nxt = DT_HL;
            LOW:          if (pwm_in)  nxt = DT_LH;
            DT_LH, DT_HL: if (dt_expired) nxt = pwm_in ? HIGH : LOW;
            default:      nxt = OFF;
         endcase
      end
   end

   // The counter is loaded only on the transition into a dead interval, so
   // later changes of dead_time do not stretch or shorten it.
   assign dt_load = is_dt(nxt) && !is_dt(state);
   assign dt_tick = is_dt(state);

   pwm_dt_timer #(.W(DT_WIDTH)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dt_load),
      .load_val (dead_time),
      .tick     (dt_tick),
      .expired  (dt_expired)
   );

   // State register, side memory and registered output decodes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= OFF;
         side          <= SIDE_NONE;
         hs_out        <= 1'b0;
         ls_out        <= 1'b0;
         dt_active     <= 1'b0;
         fault_latched <= 1'b0;
         pulse_drop    <= 1'b0;
      end else begin
         state <= nxt;
         if (dt_load)
            side <= (state == HIGH) ? SIDE_HIGH :
                    (state == LOW)  ? SIDE_LOW  : SIDE_NONE;
         hs_out        <= (nxt == HIGH);
         ls_out        <= (nxt == LOW);
         dt_active     <= is_dt(nxt);
         fault_latched <= (nxt == FAULT);
         // Returning to the side that was on before means the opposite pulse
         // was too short to survive the dead interval.
         pulse_drop    <= is_dt(state) &&
                          (((nxt == HIGH) && (side == SIDE_HIGH)) ||
                           ((nxt == LOW)  && (side == SIDE_LOW)));
      end
   end

endmodule
